// File: rtl/data_mem_ctrl.sv
// ============================================================================
// data_mem_ctrl : RV32 data-memory controller, byte-masked word RAM with wait states
// Rev 1.0
// ============================================================================
`default_nettype none

module data_mem_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_mask,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] C_WAIT_LOAD = 3'(WAIT_CYCLES);

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [31:2]       addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        mask_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_err_q;
  logic              accept;
  logic              access;
  logic              out_of_range;
  logic [ADDR_W-1:0] word_idx;
  logic              unused_addr_lsbs;

  logic [31:0] mem_q [2**ADDR_W];

  assign word_idx         = addr_q[ADDR_W+1:2];
  assign out_of_range     = |addr_q[31:ADDR_W+2];
  assign unused_addr_lsbs = ^req_addr[1:0];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_WAIT;
          cnt_d   = C_WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = (state_q == S_IDLE);
    accept    = (state_q == S_IDLE) && req_valid;
    access    = (state_q == S_WAIT) && (cnt_q == 3'd0);
    stall     = (state_q == S_WAIT) || accept;
    rsp_valid = (state_q == S_RESP);
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Request fields are frozen at the accept edge; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr[31:2];
      wdata_q <= req_wdata;
      mask_q  <= req_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else if (access) begin
      rsp_err_q <= out_of_range;
      if (!we_q) begin
        rsp_rdata_q <= out_of_range ? 32'd0 : mem_q[word_idx];
      end
    end
  end

  // Reset gates the write so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (rst_n && access && we_q && !out_of_range) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) begin
          mem_q[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire
